satd_block_loader: RTL and testbench

Ping-pong block buffer that sits directly upstream of the SATD core. It accepts one row of original samples and one row of candidate samples per cycle over a valid/ready stream. It assembles ROWS rows into the flat ORG/CUR vectors the SATD core consumes. While the SATD core reads one complete block, the next block loads into the other bank.

---
 rtl/satd_block_loader_pkg.sv | 24 ++
 rtl/satd_block_loader_if.sv | 30 +++
 rtl/satd_row_bank.sv | 40 ++++
 rtl/satd_block_loader.sv | 83 ++++++++
 tb/tb_satd_block_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/satd_block_loader_pkg.sv
// Block geometry shared by the SATD loader, the SATD core and their benches.
// Also holds the loader's debug snapshot type.
package satd_block_loader_pkg;

  localparam int WIDTH      = 8;
  localparam int SAMPLES    = 8;
  localparam int ROWS       = 16;
  localparam int ROW_BITS   = SAMPLES * WIDTH;
  localparam int BLOCK_BITS = ROWS * ROW_BITS;
  localparam int CNT_BITS   = $clog2(ROWS);

  typedef logic [ROW_BITS-1:0]   row_t;
  typedef logic [BLOCK_BITS-1:0] block_t;
  typedef logic [CNT_BITS-1:0]   row_idx_t;

  // Control state of the loader, exported for checkers.
  typedef struct packed {
    logic [1:0] full;
    logic       wr_bank;
    logic       rd_bank;
    row_idx_t   row_cnt;
  } loader_dbg_t;

endpackage

// File: rtl/satd_block_loader_if.sv
// Row-in / block-out stream bundle between a row source, the loader and the SATD core.
// master = source/sink side, slave = loader.
interface satd_block_loader_if;
  import satd_block_loader_pkg::*;

  // Both streams use valid/ready: a transfer happens on a rising clk edge where
  // valid && ready; valid and its payload are held until that edge.
  logic        in_valid;
  logic        in_ready;
  row_t        in_org_row;
  row_t        in_cur_row;
  logic        in_abort;
  logic        out_valid;
  logic        out_ready;
  block_t      ORG;
  block_t      CUR;
  logic        busy;
  loader_dbg_t dbg;

  modport master (
    output in_valid, in_org_row, in_cur_row, in_abort, out_ready,
    input  in_ready, out_valid, ORG, CUR, busy, dbg
  );

  modport slave (
    input  in_valid, in_org_row, in_cur_row, in_abort, out_ready,
    output in_ready, out_valid, ORG, CUR, busy, dbg
  );

endinterface

// File: rtl/satd_row_bank.sv
// One bank of the ping-pong buffer: ORG and CUR blocks written a row at a time.
// Row 0 maps to the MSBs of the flat block outputs.
module satd_row_bank
  import satd_block_loader_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  row_idx_t row_idx,
  input  row_t     org_row,
  input  row_t     cur_row,
  output block_t   org_blk,
  output block_t   cur_blk
);

  row_t org_mem [ROWS];
  row_t cur_mem [ROWS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        org_mem[i] <= '0;
        cur_mem[i] <= '0;
      end
    end else if (wr_en) begin
      org_mem[row_idx] <= org_row;
      cur_mem[row_idx] <= cur_row;
    end
  end

  always_comb begin
    org_blk = '0;
    cur_blk = '0;
    for (int i = 0; i < ROWS; i++) begin
      org_blk[BLOCK_BITS-1-i*ROW_BITS -: ROW_BITS] = org_mem[i];
      cur_blk[BLOCK_BITS-1-i*ROW_BITS -: ROW_BITS] = cur_mem[i];
    end
  end

endmodule

// File: rtl/satd_block_loader.sv
// Ping-pong block loader ahead of the SATD core: rows fill one bank while the
// core reads the other, complete block presented on ORG/CUR.
module satd_block_loader
  import satd_block_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  satd_block_loader_if.slave   bus
);

  logic [1:0] full;
  logic       wr_bank;
  logic       rd_bank;
  row_idx_t   row_cnt;

  logic       accept;
  logic       consume;
  logic       last_row;
  block_t     org_b [2];
  block_t     cur_b [2];

  // in_ready depends only on registered state and in_abort, never on out_ready.
  assign bus.in_ready = !full[wr_bank] && !bus.in_abort;
  assign accept       = bus.in_valid && bus.in_ready;
  assign consume      = full[rd_bank] && bus.out_ready;
  assign last_row     = (row_cnt == row_idx_t'(ROWS - 1));

  satd_row_bank u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && !wr_bank),
    .row_idx (row_cnt),
    .org_row (bus.in_org_row),
    .cur_row (bus.in_cur_row),
    .org_blk (org_b[0]),
    .cur_blk (cur_b[0])
  );

  satd_row_bank u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && wr_bank),
    .row_idx (row_cnt),
    .org_row (bus.in_org_row),
    .cur_row (bus.in_cur_row),
    .org_blk (org_b[1]),
    .cur_blk (cur_b[1])
  );

  // Fill-complete and consume always target different banks, so both full
  // bit updates can land in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      row_cnt <= '0;
    end else begin
      if (bus.in_abort) begin
        row_cnt <= '0;
      end else if (accept) begin
        if (last_row) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
          row_cnt       <= '0;
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end
      if (consume) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= !rd_bank;
      end
    end
  end

  assign bus.out_valid = full[rd_bank];
  assign bus.ORG       = rd_bank ? org_b[1] : org_b[0];
  assign bus.CUR       = rd_bank ? cur_b[1] : cur_b[0];
  assign bus.busy      = (row_cnt != '0);
  assign bus.dbg       = '{full: full, wr_bank: wr_bank, rd_bank: rd_bank, row_cnt: row_cnt};

endmodule

// File: tb/tb_satd_block_loader.sv
// Bench for satd_block_loader: per-cycle vector table, directed multi-cycle
// sequences and a random-gap run checked against a block queue.
module tb_satd_block_loader;
  import satd_block_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;

  satd_block_loader_if bus ();

  satd_block_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [2*BLOCK_BITS-1:0] exp_q [$];
  int     pop_cyc [$];
  logic   sb_en    = 1'b0;
  logic   hold_v   = 1'b0;
  logic   drv_done = 1'b0;
  block_t hold_org;
  block_t hold_cur;
  block_t zero_blk = '0;

  typedef struct {
    logic valid;
    logic abort;
    logic oready;
    row_t org;
    row_t cur;
    logic exp_ready;
    logic exp_busy;
    logic exp_ov;
  } vec_t;

  vec_t vecs [26];

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic chk_blk(input string name, input block_t got, input block_t exp);
    logic shown;
    checks++;
    if (got !== exp) begin
      errors++;
      shown = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        if (!shown && got[BLOCK_BITS-1-r*ROW_BITS -: ROW_BITS] !== exp[BLOCK_BITS-1-r*ROW_BITS -: ROW_BITS]) begin
          $display("FAIL %s row %0d got %h exp %h", name, r,
                   got[BLOCK_BITS-1-r*ROW_BITS -: ROW_BITS], exp[BLOCK_BITS-1-r*ROW_BITS -: ROW_BITS]);
          shown = 1'b1;
        end
      end
    end
  endtask

  function automatic block_t rand_blk();
    block_t b;
    for (int i = 0; i < BLOCK_BITS / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  task automatic monitor();
    logic [2*BLOCK_BITS-1:0] e;
    forever begin
      @(negedge clk);
      if (!sb_en || rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("hold_valid", 64'(bus.out_valid), 64'd1);
          chk_blk("hold_org", bus.ORG, hold_org);
          chk_blk("hold_cur", bus.CUR, hold_cur);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_block", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk_blk("sb_org", bus.ORG, e[2*BLOCK_BITS-1:BLOCK_BITS]);
            chk_blk("sb_cur", bus.CUR, e[BLOCK_BITS-1:0]);
          end
          pop_cyc.push_back(cyc + 1);
        end
        hold_v   = bus.out_valid && !bus.out_ready;
        hold_org = bus.ORG;
        hold_cur = bus.CUR;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    sb_en          = 1'b0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_abort   = 1'b0;
    bus.out_ready  = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_dbg", 64'(bus.dbg), 64'd0);
    chk_blk("rst_org", bus.ORG, zero_blk);
    chk_blk("rst_cur", bus.CUR, zero_blk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_row(input row_t o, input row_t c);
    int n;
    bus.in_valid   = 1'b1;
    bus.in_org_row = o;
    bus.in_cur_row = c;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) chk("row_accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input block_t o, input block_t c);
    for (int r = 0; r < ROWS; r++)
      send_row(o[BLOCK_BITS-1-r*ROW_BITS -: ROW_BITS], c[BLOCK_BITS-1-r*ROW_BITS -: ROW_BITS]);
    exp_q.push_back({o, c});
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    block_t t1_org, t1_cur, y_org, y_cur;
    block_t b_org [3];
    block_t b_cur [3];
    logic [7:0] r8;
    int start;

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_abort   = 1'b0;
    bus.in_org_row = '0;
    bus.in_cur_row = '0;
    bus.out_ready  = 1'b0;

    fork
      monitor();
      begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Table: first block rows, latency edge, then 7 rows of a block that gets aborted.
    for (int i = 0; i < 26; i++) begin
      vecs[i].valid = 1'b0; vecs[i].abort = 1'b0; vecs[i].oready = 1'b0;
      vecs[i].org = '0; vecs[i].cur = '0;
      vecs[i].exp_ready = 1'b1; vecs[i].exp_busy = 1'b0; vecs[i].exp_ov = 1'b1;
    end
    for (int r = 0; r < 16; r++) begin
      r8 = 8'(r);
      vecs[r].valid    = 1'b1;
      vecs[r].org      = {8{r8}};
      vecs[r].cur      = ~{8{r8}};
      vecs[r].exp_busy = (r != 0);
      vecs[r].exp_ov   = 1'b0;
      t1_org[BLOCK_BITS-1-r*ROW_BITS -: ROW_BITS] = {8{r8}};
      t1_cur[BLOCK_BITS-1-r*ROW_BITS -: ROW_BITS] = ~{8{r8}};
    end
    for (int k = 0; k < 7; k++) begin
      r8 = 8'hA0 + 8'(k);
      vecs[17+k].valid    = 1'b1;
      vecs[17+k].org      = {8{r8}};
      vecs[17+k].cur      = ~{8{r8}};
      vecs[17+k].exp_busy = (k != 0);
    end
    vecs[24].valid     = 1'b1;
    vecs[24].abort     = 1'b1;
    vecs[24].org       = {8{8'hA7}};
    vecs[24].cur       = ~{8{8'hA7}};
    vecs[24].exp_ready = 1'b0;
    vecs[24].exp_busy  = 1'b1;

    do_reset();

    for (int i = 0; i < 26; i++) begin
      bus.in_valid   = vecs[i].valid;
      bus.in_abort   = vecs[i].abort;
      bus.out_ready  = vecs[i].oready;
      bus.in_org_row = vecs[i].org;
      bus.in_cur_row = vecs[i].cur;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_ov));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_abort = 1'b0;

    @(negedge clk);
    chk("t1_org_row0", bus.ORG[1023:960], 64'h0000_0000_0000_0000);
    chk("t1_org_row15", bus.ORG[63:0], 64'h0F0F_0F0F_0F0F_0F0F);
    chk_blk("t1_org", bus.ORG, t1_org);
    chk_blk("t1_cur", bus.CUR, t1_cur);

    // Consume block 0, then the post-abort block must come out clean.
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("after_consume_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    sb_en = 1'b1;
    y_org = rand_blk();
    y_cur = rand_blk();
    send_block(y_org, y_cur);
    drain();

    // Back-to-back streaming with out_ready held high.
    do_reset();
    sb_en = 1'b1;
    bus.out_ready = 1'b1;
    pop_cyc.delete();
    start = cyc;
    for (int b = 0; b < 3; b++) send_block(rand_blk(), rand_blk());
    chk("stream_cycles", 64'(cyc - start), 64'd48);
    repeat (3) @(posedge clk);
    #1;
    chk("stream_pulses", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3) begin
      chk("stream_first_pulse", 64'(pop_cyc[0] - start), 64'd17);
      chk("stream_gap01", 64'(pop_cyc[1] - pop_cyc[0]), 64'd16);
      chk("stream_gap12", 64'(pop_cyc[2] - pop_cyc[1]), 64'd16);
    end
    bus.out_ready = 1'b0;

    // Both banks full: stall, single consume, in_ready returns next cycle.
    do_reset();
    sb_en = 1'b1;
    for (int b = 0; b < 3; b++) begin
      b_org[b] = rand_blk();
      b_cur[b] = rand_blk();
    end
    send_block(b_org[0], b_cur[0]);
    send_block(b_org[1], b_cur[1]);
    bus.in_valid   = 1'b1;
    bus.in_org_row = b_org[2][BLOCK_BITS-1 -: ROW_BITS];
    bus.in_cur_row = b_cur[2][BLOCK_BITS-1 -: ROW_BITS];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    chk("stall_full", 64'(bus.dbg.full), 64'd3);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("consume_cycle_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("ready_return", 64'(bus.in_ready), 64'd1);
    chk("ready_return_ov", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    for (int r = 1; r < ROWS; r++)
      send_row(b_org[2][BLOCK_BITS-1-r*ROW_BITS -: ROW_BITS], b_cur[2][BLOCK_BITS-1-r*ROW_BITS -: ROW_BITS]);
    exp_q.push_back({b_org[2], b_cur[2]});
    drain();

    // Asynchronous reset mid-block and with a block on the output.
    do_reset();
    sb_en = 1'b1;
    for (int r = 0; r < 9; r++) send_row(row_t'($urandom), row_t'($urandom));
    chk("midblock_busy", 64'(bus.busy), 64'd1);
    do_reset();
    sb_en = 1'b1;
    send_block(rand_blk(), rand_blk());
    @(negedge clk);
    chk("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    do_reset();
    sb_en = 1'b1;
    send_block(rand_blk(), rand_blk());
    drain();

    // Random gaps on both sides over 200 blocks.
    do_reset();
    sb_en = 1'b1;
    pop_cyc.delete();
    drv_done = 1'b0;
    fork
      begin
        block_t ro, rc;
        for (int b = 0; b < 200; b++) begin
          ro = rand_blk();
          rc = rand_blk();
          for (int r = 0; r < ROWS; r++) begin
            if ($urandom_range(0, 3) == 0) begin
              bus.in_valid = 1'b0;
              repeat ($urandom_range(1, 3)) @(posedge clk);
              #1;
            end
            send_row(ro[BLOCK_BITS-1-r*ROW_BITS -: ROW_BITS], rc[BLOCK_BITS-1-r*ROW_BITS -: ROW_BITS]);
          end
          exp_q.push_back({ro, rc});
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    chk("random_blocks", 64'(pop_cyc.size()), 64'd200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
